hypercorex_csr_regfile: RTL and testbench

- CSR register file and request/response front-end for the HDC core; directly consumes the CSR register/bit address map.
- Decodes host CSR reads/writes at register indices 0-15 and drives core control fields, pulses and instruction-memory write strobes.
- Buffers associative-memory (AM) predictions in a small FIFO that the host drains through CSR reads.
- Sits between the host CSR bus and the core, instruction memory and loop controller.

---
 rtl/hypercorex_csr_regfile.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_hypercorex_csr_regfile.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hypercorex_csr_regfile.sv
// hypercorex_csr_regfile: host CSR front-end for the HDC core.
// Control/status registers, instruction write port and AM prediction FIFO.
module hypercorex_csr_regfile #(
    parameter int unsigned CsrDataWidth     = 32,
    parameter int unsigned CsrAddrWidth     = 32,
    parameter int unsigned InstAddrWidth    = 8,
    parameter int unsigned PredictWidth     = 8,
    parameter int unsigned PredictFifoDepth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [CsrAddrWidth-1:0]  csr_req_addr_i,
    input  logic [CsrDataWidth-1:0]  csr_req_data_i,
    input  logic                     csr_req_write_i,
    input  logic                     csr_req_valid_i,
    output logic                     csr_req_ready_o,
    output logic [CsrDataWidth-1:0]  csr_rsp_data_o,
    output logic                     csr_rsp_valid_o,
    input  logic                     csr_rsp_ready_i,
    input  logic                     core_busy_i,
    input  logic [PredictWidth-1:0]  am_predict_i,
    input  logic                     am_predict_valid_i,
    input  logic [InstAddrWidth-1:0] inst_pc_i,
    input  logic [CsrDataWidth-1:0]  inst_at_addr_i,
    input  logic [CsrDataWidth-1:0]  observable_i,
    output logic                     start_o,
    output logic                     core_clr_o,
    output logic                     seq_test_o,
    output logic [1:0]               ima_mux_o,
    output logic                     imb_mux_o,
    output logic                     inst_write_mode_o,
    output logic                     inst_dbg_mode_o,
    output logic                     inst_clr_o,
    output logic                     inst_wr_en_o,
    output logic [InstAddrWidth-1:0] inst_wr_addr_o,
    output logic [CsrDataWidth-1:0]  inst_wr_data_o,
    output logic [InstAddrWidth-1:0] inst_rddbg_addr_o,
    output logic [1:0]               loop_mode_o,
    output logic [23:0]              loop_jump_addr_o,
    output logic [23:0]              loop_end_addr_o,
    output logic [23:0]              loop_count_o,
    output logic [CsrDataWidth-1:0]  slice_mode_o,
    output logic [CsrDataWidth-1:0]  slice_num_elem_o
);

    localparam int unsigned PtrW = $clog2(PredictFifoDepth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FifoFull = CntW'(PredictFifoDepth);

    logic                     rsp_valid_q, rsp_valid_d;
    logic [CsrDataWidth-1:0]  rsp_data_q, rsp_data_d;
    logic                     start_q, start_d;
    logic                     core_clr_q, core_clr_d;
    logic                     seq_test_q, seq_test_d;
    logic [1:0]               ima_mux_q, ima_mux_d;
    logic                     imb_mux_q, imb_mux_d;
    logic                     inst_wmode_q, inst_wmode_d;
    logic                     inst_dbg_q, inst_dbg_d;
    logic                     inst_clr_q, inst_clr_d;
    logic [InstAddrWidth-1:0] inst_addr_q, inst_addr_d;
    logic [CsrDataWidth-1:0]  inst_data_q, inst_data_d;
    logic                     inst_wr_en_q, inst_wr_en_d;
    logic [InstAddrWidth-1:0] inst_wr_addr_q, inst_wr_addr_d;
    logic [InstAddrWidth-1:0] dbg_addr_q, dbg_addr_d;
    logic [1:0]               loop_mode_q, loop_mode_d;
    logic [23:0]              loop_jump_q, loop_jump_d;
    logic [23:0]              loop_end_q, loop_end_d;
    logic [23:0]              loop_count_q, loop_count_d;
    logic [CsrDataWidth-1:0]  slice_mode_q, slice_mode_d;
    logic [CsrDataWidth-1:0]  slice_num_q, slice_num_d;

    logic [PredictWidth-1:0]  fifo_mem_q [PredictFifoDepth];
    logic [PredictWidth-1:0]  fifo_mem_d [PredictFifoDepth];
    logic [PtrW-1:0]          fifo_rptr_q, fifo_rptr_d;
    logic [PtrW-1:0]          fifo_wptr_q, fifo_wptr_d;
    logic [CntW-1:0]          fifo_cnt_q, fifo_cnt_d;
    logic                     fifo_ovf_q, fifo_ovf_d;

    logic                     req_fire;
    logic                     req_wr;
    logic                     req_rd;
    logic                     addr_hit;
    logic [3:0]               req_idx;
    logic [15:0]              wr_hit;
    logic [CsrDataWidth-1:0]  rd_data;
    logic [PredictWidth-1:0]  fifo_head;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     fifo_pop;
    logic                     fifo_push;
    logic                     fifo_drop;
    logic                     fifo_clr;

    assign csr_req_ready_o = !rsp_valid_q || csr_rsp_ready_i;
    assign req_fire  = csr_req_valid_i && csr_req_ready_o;
    assign addr_hit  = (csr_req_addr_i < CsrAddrWidth'(16));
    assign req_idx   = csr_req_addr_i[3:0];
    assign req_wr    = req_fire && csr_req_write_i && addr_hit;
    assign req_rd    = req_fire && !csr_req_write_i && addr_hit;
    assign wr_hit    = req_wr ? (16'd1 << req_idx) : 16'd0;

    assign fifo_head  = fifo_mem_q[fifo_rptr_q];
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == FifoFull);
    assign fifo_pop   = req_rd && (req_idx == 4'd2) && !fifo_empty;
    assign fifo_push  = am_predict_valid_i && (!fifo_full || fifo_pop);
    assign fifo_drop  = am_predict_valid_i && fifo_full && !fifo_pop;
    assign fifo_clr   = wr_hit[0] && csr_req_data_i[6];

    // Read data mux, sampled in the accept cycle.
    always_comb begin
        rd_data = '0;
        unique case (req_idx)
            4'd0: begin
                rd_data[1]   = core_busy_i;
                rd_data[2]   = seq_test_q;
                rd_data[4:3] = ima_mux_q;
                rd_data[5]   = imb_mux_q;
            end
            4'd1: rd_data[CntW-1:0] = fifo_cnt_q;
            4'd2: begin
                if (!fifo_empty) begin
                    rd_data[PredictWidth-1:0] = fifo_head;
                end
                rd_data[8] = !fifo_empty;
                rd_data[9] = fifo_ovf_q;
            end
            4'd3: begin
                rd_data[0] = inst_wmode_q;
                rd_data[1] = inst_dbg_q;
            end
            4'd4: rd_data[InstAddrWidth-1:0] = inst_addr_q;
            4'd5: rd_data = inst_data_q;
            4'd6: rd_data[InstAddrWidth-1:0] = dbg_addr_q;
            4'd7: rd_data[InstAddrWidth-1:0] = inst_pc_i;
            4'd8: rd_data = inst_at_addr_i;
            4'd9: rd_data[1:0] = loop_mode_q;
            4'd10: rd_data[23:0] = loop_jump_q;
            4'd11: rd_data[23:0] = loop_end_q;
            4'd12: rd_data[23:0] = loop_count_q;
            4'd13: rd_data = slice_mode_q;
            4'd14: rd_data = slice_num_q;
            default: rd_data = observable_i;
        endcase
        if (!addr_hit) begin
            rd_data = '0;
        end
    end

    // Response register: load on accept, hold until the host consumes it.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (req_fire) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = csr_req_write_i ? '0 : rd_data;
        end else if (csr_rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Control registers, pulses and the auto-incrementing write port.
    always_comb begin
        start_d        = wr_hit[0] && csr_req_data_i[0] && !core_busy_i;
        core_clr_d     = fifo_clr;
        seq_test_d     = seq_test_q;
        ima_mux_d      = ima_mux_q;
        imb_mux_d      = imb_mux_q;
        inst_wmode_d   = inst_wmode_q;
        inst_dbg_d     = inst_dbg_q;
        inst_clr_d     = wr_hit[3] && csr_req_data_i[2];
        inst_addr_d    = inst_addr_q;
        inst_data_d    = inst_data_q;
        inst_wr_en_d   = wr_hit[5] && inst_wmode_q;
        inst_wr_addr_d = inst_wr_addr_q;
        dbg_addr_d     = dbg_addr_q;
        loop_mode_d    = loop_mode_q;
        loop_jump_d    = loop_jump_q;
        loop_end_d     = loop_end_q;
        loop_count_d   = loop_count_q;
        slice_mode_d   = slice_mode_q;
        slice_num_d    = slice_num_q;
        if (wr_hit[0]) begin
            seq_test_d = csr_req_data_i[2];
            ima_mux_d  = csr_req_data_i[4:3];
            imb_mux_d  = csr_req_data_i[5];
        end
        if (wr_hit[3]) begin
            inst_wmode_d = csr_req_data_i[0];
            inst_dbg_d   = csr_req_data_i[1];
        end
        if (wr_hit[4]) begin
            inst_addr_d = csr_req_data_i[InstAddrWidth-1:0];
        end
        if (wr_hit[5]) begin
            inst_data_d = csr_req_data_i;
            if (inst_wmode_q) begin
                inst_wr_addr_d = inst_addr_q;
                inst_addr_d    = inst_addr_q + InstAddrWidth'(1);
            end
        end
        if (wr_hit[6]) begin
            dbg_addr_d = csr_req_data_i[InstAddrWidth-1:0];
        end
        if (wr_hit[9]) begin
            loop_mode_d = csr_req_data_i[1:0];
        end
        if (wr_hit[10]) begin
            loop_jump_d = csr_req_data_i[23:0];
        end
        if (wr_hit[11]) begin
            loop_end_d = csr_req_data_i[23:0];
        end
        if (wr_hit[12]) begin
            loop_count_d = csr_req_data_i[23:0];
        end
        if (wr_hit[13]) begin
            slice_mode_d = csr_req_data_i;
        end
        if (wr_hit[14]) begin
            slice_num_d = csr_req_data_i;
        end
    end

    // Prediction FIFO: a pop frees a slot for a same-cycle push; clear wins.
    always_comb begin
        fifo_mem_d  = fifo_mem_q;
        fifo_rptr_d = fifo_rptr_q;
        fifo_wptr_d = fifo_wptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        fifo_ovf_d  = fifo_ovf_q;
        if (fifo_push) begin
            fifo_mem_d[fifo_wptr_q] = am_predict_i;
            fifo_wptr_d = fifo_wptr_q + PtrW'(1);
        end
        if (fifo_pop) begin
            fifo_rptr_d = fifo_rptr_q + PtrW'(1);
        end
        if (fifo_push && !fifo_pop) begin
            fifo_cnt_d = fifo_cnt_q + CntW'(1);
        end else if (fifo_pop && !fifo_push) begin
            fifo_cnt_d = fifo_cnt_q - CntW'(1);
        end
        if (fifo_drop) begin
            fifo_ovf_d = 1'b1;
        end
        if (fifo_clr) begin
            fifo_rptr_d = '0;
            fifo_wptr_d = '0;
            fifo_cnt_d  = '0;
            fifo_ovf_d  = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            start_q        <= 1'b0;
            core_clr_q     <= 1'b0;
            seq_test_q     <= 1'b0;
            ima_mux_q      <= '0;
            imb_mux_q      <= 1'b0;
            inst_wmode_q   <= 1'b0;
            inst_dbg_q     <= 1'b0;
            inst_clr_q     <= 1'b0;
            inst_addr_q    <= '0;
            inst_data_q    <= '0;
            inst_wr_en_q   <= 1'b0;
            inst_wr_addr_q <= '0;
            dbg_addr_q     <= '0;
            loop_mode_q    <= '0;
            loop_jump_q    <= '0;
            loop_end_q     <= '0;
            loop_count_q   <= '0;
            slice_mode_q   <= '0;
            slice_num_q    <= '0;
            fifo_mem_q     <= '{default: '0};
            fifo_rptr_q    <= '0;
            fifo_wptr_q    <= '0;
            fifo_cnt_q     <= '0;
            fifo_ovf_q     <= 1'b0;
        end else begin
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            start_q        <= start_d;
            core_clr_q     <= core_clr_d;
            seq_test_q     <= seq_test_d;
            ima_mux_q      <= ima_mux_d;
            imb_mux_q      <= imb_mux_d;
            inst_wmode_q   <= inst_wmode_d;
            inst_dbg_q     <= inst_dbg_d;
            inst_clr_q     <= inst_clr_d;
            inst_addr_q    <= inst_addr_d;
            inst_data_q    <= inst_data_d;
            inst_wr_en_q   <= inst_wr_en_d;
            inst_wr_addr_q <= inst_wr_addr_d;
            dbg_addr_q     <= dbg_addr_d;
            loop_mode_q    <= loop_mode_d;
            loop_jump_q    <= loop_jump_d;
            loop_end_q     <= loop_end_d;
            loop_count_q   <= loop_count_d;
            slice_mode_q   <= slice_mode_d;
            slice_num_q    <= slice_num_d;
            fifo_mem_q     <= fifo_mem_d;
            fifo_rptr_q    <= fifo_rptr_d;
            fifo_wptr_q    <= fifo_wptr_d;
            fifo_cnt_q     <= fifo_cnt_d;
            fifo_ovf_q     <= fifo_ovf_d;
        end
    end

    assign csr_rsp_valid_o   = rsp_valid_q;
    assign csr_rsp_data_o    = rsp_data_q;
    assign start_o           = start_q;
    assign core_clr_o        = core_clr_q;
    assign seq_test_o        = seq_test_q;
    assign ima_mux_o         = ima_mux_q;
    assign imb_mux_o         = imb_mux_q;
    assign inst_write_mode_o = inst_wmode_q;
    assign inst_dbg_mode_o   = inst_dbg_q;
    assign inst_clr_o        = inst_clr_q;
    assign inst_wr_en_o      = inst_wr_en_q;
    assign inst_wr_addr_o    = inst_wr_addr_q;
    assign inst_wr_data_o    = inst_data_q;
    assign inst_rddbg_addr_o = dbg_addr_q;
    assign loop_mode_o       = loop_mode_q;
    assign loop_jump_addr_o  = loop_jump_q;
    assign loop_end_addr_o   = loop_end_q;
    assign loop_count_o      = loop_count_q;
    assign slice_mode_o      = slice_mode_q;
    assign slice_num_elem_o  = slice_num_q;

endmodule

// File: tb/tb_hypercorex_csr_regfile.sv
// tb_hypercorex_csr_regfile: directed and random CSR traffic checked
// against a queue-based reference model of the register map.
module tb_hypercorex_csr_regfile;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] csr_req_addr_i;
    logic [31:0] csr_req_data_i;
    logic        csr_req_write_i;
    logic        csr_req_valid_i;
    logic        csr_req_ready_o;
    logic [31:0] csr_rsp_data_o;
    logic        csr_rsp_valid_o;
    logic        csr_rsp_ready_i;
    logic        core_busy_i;
    logic [7:0]  am_predict_i;
    logic        am_predict_valid_i;
    logic [7:0]  inst_pc_i;
    logic [31:0] inst_at_addr_i;
    logic [31:0] observable_i;
    logic        start_o;
    logic        core_clr_o;
    logic        seq_test_o;
    logic [1:0]  ima_mux_o;
    logic        imb_mux_o;
    logic        inst_write_mode_o;
    logic        inst_dbg_mode_o;
    logic        inst_clr_o;
    logic        inst_wr_en_o;
    logic [7:0]  inst_wr_addr_o;
    logic [31:0] inst_wr_data_o;
    logic [7:0]  inst_rddbg_addr_o;
    logic [1:0]  loop_mode_o;
    logic [23:0] loop_jump_addr_o;
    logic [23:0] loop_end_addr_o;
    logic [23:0] loop_count_o;
    logic [31:0] slice_mode_o;
    logic [31:0] slice_num_elem_o;

    int checks = 0;
    int errors = 0;

    logic        m_seq;
    logic [1:0]  m_ima;
    logic        m_imb;
    logic        m_wm;
    logic        m_dbg;
    logic [7:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [7:0]  m_dbgaddr;
    logic [1:0]  m_lmode;
    logic [23:0] m_loop [3];
    logic [31:0] m_slice [2];
    logic [7:0]  m_fifo [$];
    logic        m_ovf;

    hypercorex_csr_regfile dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .csr_req_addr_i     (csr_req_addr_i),
        .csr_req_data_i     (csr_req_data_i),
        .csr_req_write_i    (csr_req_write_i),
        .csr_req_valid_i    (csr_req_valid_i),
        .csr_req_ready_o    (csr_req_ready_o),
        .csr_rsp_data_o     (csr_rsp_data_o),
        .csr_rsp_valid_o    (csr_rsp_valid_o),
        .csr_rsp_ready_i    (csr_rsp_ready_i),
        .core_busy_i        (core_busy_i),
        .am_predict_i       (am_predict_i),
        .am_predict_valid_i (am_predict_valid_i),
        .inst_pc_i          (inst_pc_i),
        .inst_at_addr_i     (inst_at_addr_i),
        .observable_i       (observable_i),
        .start_o            (start_o),
        .core_clr_o         (core_clr_o),
        .seq_test_o         (seq_test_o),
        .ima_mux_o          (ima_mux_o),
        .imb_mux_o          (imb_mux_o),
        .inst_write_mode_o  (inst_write_mode_o),
        .inst_dbg_mode_o    (inst_dbg_mode_o),
        .inst_clr_o         (inst_clr_o),
        .inst_wr_en_o       (inst_wr_en_o),
        .inst_wr_addr_o     (inst_wr_addr_o),
        .inst_wr_data_o     (inst_wr_data_o),
        .inst_rddbg_addr_o  (inst_rddbg_addr_o),
        .loop_mode_o        (loop_mode_o),
        .loop_jump_addr_o   (loop_jump_addr_o),
        .loop_end_addr_o    (loop_end_addr_o),
        .loop_count_o       (loop_count_o),
        .slice_mode_o       (slice_mode_o),
        .slice_num_elem_o   (slice_num_elem_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_seq = 0; m_ima = 0; m_imb = 0;
        m_wm = 0; m_dbg = 0;
        m_waddr = 0; m_wdata = 0; m_dbgaddr = 0;
        m_lmode = 0;
        for (int i = 0; i < 3; i++) m_loop[i] = 0;
        for (int i = 0; i < 2; i++) m_slice[i] = 0;
        m_fifo.delete();
        m_ovf = 0;
    endtask

    // One accepted request: returns read value, pulses {strobe,iclr,clr,start}.
    task automatic model_step(input logic [31:0] addr, input logic wr, input logic [31:0] d,
                              input logic push, input logic [7:0] pv,
                              output logic [31:0] rd, output logic [3:0] pul,
                              output logic [7:0] st_addr);
        int idx;
        bit hit;
        rd = 0; pul = 0; st_addr = 0;
        hit = (addr < 32'd16);
        idx = int'(addr[3:0]);
        if (hit && !wr) begin
            case (idx)
                0: rd = {26'd0, m_imb, m_ima, m_seq, core_busy_i, 1'b0};
                1: rd = 32'(m_fifo.size());
                2: rd = (m_fifo.size() > 0) ? {22'd0, m_ovf, 1'b1, m_fifo[0]}
                                            : {22'd0, m_ovf, 9'd0};
                3: rd = {30'd0, m_dbg, m_wm};
                4: rd = {24'd0, m_waddr};
                5: rd = m_wdata;
                6: rd = {24'd0, m_dbgaddr};
                7: rd = {24'd0, inst_pc_i};
                8: rd = inst_at_addr_i;
                9: rd = {30'd0, m_lmode};
                10, 11, 12: rd = {8'd0, m_loop[idx-10]};
                13, 14: rd = m_slice[idx-13];
                default: rd = observable_i;
            endcase
            if (idx == 2 && m_fifo.size() > 0) void'(m_fifo.pop_front());
        end
        if (hit && wr) begin
            case (idx)
                0: begin
                    pul[0] = d[0] && !core_busy_i;
                    pul[1] = d[6];
                    m_seq = d[2]; m_ima = d[4:3]; m_imb = d[5];
                end
                3: begin
                    m_wm = d[0]; m_dbg = d[1]; pul[2] = d[2];
                end
                4: m_waddr = d[7:0];
                5: begin
                    if (m_wm) begin
                        pul[3] = 1; st_addr = m_waddr; m_waddr = m_waddr + 8'd1;
                    end
                    m_wdata = d;
                end
                6: m_dbgaddr = d[7:0];
                9: m_lmode = d[1:0];
                10, 11, 12: m_loop[idx-10] = d[23:0];
                13, 14: m_slice[idx-13] = d;
                default: ;
            endcase
        end
        if (push) begin
            if (m_fifo.size() < 4) m_fifo.push_back(pv);
            else m_ovf = 1;
        end
        if (pul[1]) begin
            m_fifo.delete();
            m_ovf = 0;
        end
    endtask

    task automatic check_levels(input string tag);
        chk({tag, "_ctrl"},
            {24'd0, seq_test_o, ima_mux_o, imb_mux_o, inst_write_mode_o, inst_dbg_mode_o, loop_mode_o},
            {24'd0, m_seq, m_ima, m_imb, m_wm, m_dbg, m_lmode});
        chk({tag, "_dbg_addr"}, {24'd0, inst_rddbg_addr_o}, {24'd0, m_dbgaddr});
        chk({tag, "_loop_jump"}, {8'd0, loop_jump_addr_o}, {8'd0, m_loop[0]});
        chk({tag, "_loop_end"}, {8'd0, loop_end_addr_o}, {8'd0, m_loop[1]});
        chk({tag, "_loop_count"}, {8'd0, loop_count_o}, {8'd0, m_loop[2]});
        chk({tag, "_slice_mode"}, slice_mode_o, m_slice[0]);
        chk({tag, "_slice_num"}, slice_num_elem_o, m_slice[1]);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 32'(csr_rsp_valid_o), 32'd0);
        chk({tag, "_req_ready"}, 32'(csr_req_ready_o), 32'd1);
        chk({tag, "_pulses"}, {28'd0, start_o, core_clr_o, inst_clr_o, inst_wr_en_o}, 32'd0);
        chk({tag, "_wr_port"}, inst_wr_data_o | {24'd0, inst_wr_addr_o}, 32'd0);
        check_levels(tag);
    endtask

    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] d,
                        input logic push, input logic [7:0] pv, output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic [3:0]  pul;
        logic [7:0]  sa;
        @(negedge clk_i);
        chk("idle_pulses", {28'd0, start_o, core_clr_o, inst_clr_o, inst_wr_en_o}, 32'd0);
        chk("req_ready", 32'(csr_req_ready_o), 32'd1);
        csr_req_addr_i     = addr;
        csr_req_write_i    = wr;
        csr_req_data_i     = d;
        csr_req_valid_i    = 1'b1;
        am_predict_i       = pv;
        am_predict_valid_i = push;
        model_step(addr, wr, d, push, pv, exp_rd, pul, sa);
        @(negedge clk_i);
        csr_req_valid_i    = 1'b0;
        am_predict_valid_i = 1'b0;
        chk("rsp_valid", 32'(csr_rsp_valid_o), 32'd1);
        chk("rsp_data", csr_rsp_data_o, exp_rd);
        chk("pulses", {28'd0, start_o, core_clr_o, inst_clr_o, inst_wr_en_o},
            {28'd0, pul[0], pul[1], pul[2], pul[3]});
        if (pul[3]) begin
            chk("wr_addr", {24'd0, inst_wr_addr_o}, {24'd0, sa});
            chk("wr_data", inst_wr_data_o, d);
        end
        check_levels("lvl");
        rd = csr_rsp_data_o;
    endtask

    task automatic push_pred(input logic [7:0] pv);
        @(negedge clk_i);
        am_predict_i       = pv;
        am_predict_valid_i = 1'b1;
        @(negedge clk_i);
        am_predict_valid_i = 1'b0;
        if (m_fifo.size() < 4) m_fifo.push_back(pv);
        else m_ovf = 1;
    endtask

    initial begin
        logic [31:0] r;
        rst_i = 1; csr_req_addr_i = 0; csr_req_data_i = 0;
        csr_req_write_i = 0; csr_req_valid_i = 0; csr_rsp_ready_i = 1;
        core_busy_i = 0; am_predict_i = 0; am_predict_valid_i = 0;
        inst_pc_i = 0; inst_at_addr_i = 0; observable_i = 0;
        model_reset();
        repeat (3) @(negedge clk_i);
        rst_i = 0;
        check_reset_outputs("reset");

        // Reset readback with busy high: only reg 0 bit1 is set.
        core_busy_i = 1;
        for (int i = 0; i < 16; i++) begin
            xfer(32'(i), 1'b0, 32'd0, 1'b0, 8'd0, r);
            chk("reset_read", r, (i == 0) ? 32'h2 : 32'h0);
        end

        core_busy_i = 0;
        xfer(32'd0, 1'b1, 32'h3D, 1'b0, 8'd0, r);
        xfer(32'd0, 1'b0, 32'd0, 1'b0, 8'd0, r);
        chk("reg0_readback", r, 32'h3C);
        core_busy_i = 1;
        xfer(32'd0, 1'b1, 32'h01, 1'b0, 8'd0, r);
        core_busy_i = 0;

        xfer(32'd3, 1'b1, 32'h1, 1'b0, 8'd0, r);
        xfer(32'd4, 1'b1, 32'hFF, 1'b0, 8'd0, r);
        xfer(32'd5, 1'b1, 32'hAA, 1'b0, 8'd0, r);
        xfer(32'd5, 1'b1, 32'hBB, 1'b0, 8'd0, r);
        xfer(32'd4, 1'b0, 32'd0, 1'b0, 8'd0, r);
        chk("inst_addr_wrap", r, 32'h01);

        for (int i = 1; i <= 5; i++) push_pred(8'(i));
        xfer(32'd1, 1'b0, 32'd0, 1'b0, 8'd0, r);
        chk("fifo_cnt_full", r, 32'd4);
        for (int i = 0; i < 5; i++) begin
            xfer(32'd2, 1'b0, 32'd0, 1'b0, 8'd0, r);
            chk("fifo_pop", r, (i < 4) ? (32'h300 + 32'(i + 1)) : 32'h200);
            xfer(32'd1, 1'b0, 32'd0, 1'b0, 8'd0, r);
            chk("fifo_cnt", r, (i < 4) ? 32'(3 - i) : 32'd0);
        end
        xfer(32'd0, 1'b1, 32'h40, 1'b0, 8'd0, r);
        xfer(32'd2, 1'b0, 32'd0, 1'b0, 8'd0, r);
        xfer(32'd20, 1'b1, 32'hFFFF_FFFF, 1'b0, 8'd0, r);
        xfer(32'h100, 1'b0, 32'd0, 1'b0, 8'd0, r);

        for (int n = 0; n < 300; n++) begin
            int unsigned sel;
            logic [31:0] a;
            core_busy_i    = 1'($urandom_range(0, 1));
            inst_pc_i      = 8'($urandom);
            inst_at_addr_i = $urandom;
            observable_i   = $urandom;
            sel = $urandom_range(0, 19);
            a = (sel < 17) ? 32'(sel) : $urandom;
            xfer(a, 1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 1)), 8'($urandom), r);
        end

        // Stalled response: held stable, a pending request is not accepted.
        xfer(32'd13, 1'b1, 32'h1234_5678, 1'b0, 8'd0, r);
        @(negedge clk_i);
        csr_rsp_ready_i = 0;
        csr_req_addr_i = 32'd13; csr_req_write_i = 0; csr_req_valid_i = 1;
        @(negedge clk_i);
        csr_req_write_i = 1; csr_req_data_i = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", 32'(csr_rsp_valid_o), 32'd1);
            chk("hold_data", csr_rsp_data_o, 32'h1234_5678);
            chk("hold_ready", 32'(csr_req_ready_o), 32'd0);
            chk("hold_no_accept", slice_mode_o, 32'h1234_5678);
            @(negedge clk_i);
        end
        csr_rsp_ready_i = 1;
        @(negedge clk_i);
        csr_req_valid_i = 0;
        m_slice[0] = 32'hDEAD_BEEF;
        chk("b2b_valid", 32'(csr_rsp_valid_o), 32'd1);
        chk("b2b_data", csr_rsp_data_o, 32'd0);
        chk("b2b_write", slice_mode_o, 32'hDEAD_BEEF);

        // Reset asserted while a response is stalled.
        @(negedge clk_i);
        csr_rsp_ready_i = 0;
        csr_req_addr_i = 32'd14; csr_req_write_i = 0; csr_req_valid_i = 1;
        @(negedge clk_i);
        csr_req_valid_i = 0;
        chk("stall_valid", 32'(csr_rsp_valid_o), 32'd1);
        chk("stall_data", csr_rsp_data_o, m_slice[1]);
        chk("stall_ready", 32'(csr_req_ready_o), 32'd0);
        @(negedge clk_i);
        chk("stall_valid2", 32'(csr_rsp_valid_o), 32'd1);
        rst_i = 1;
        @(negedge clk_i);
        rst_i = 0;
        model_reset();
        check_reset_outputs("mid_reset");
        csr_rsp_ready_i = 1;
        xfer(32'd13, 1'b0, 32'd0, 1'b0, 8'd0, r);
        chk("post_reset_slice", r, 32'd0);
        xfer(32'd1, 1'b0, 32'd0, 1'b0, 8'd0, r);
        xfer(32'd2, 1'b0, 32'd0, 1'b0, 8'd0, r);
        chk("post_reset_fifo", r, 32'd0);
        xfer(32'd4, 1'b0, 32'd0, 1'b0, 8'd0, r);
        xfer(32'd3, 1'b0, 32'd0, 1'b0, 8'd0, r);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
